rcu: RTL and testbench

Receiver control unit for the USB full-speed receiver. Sits directly downstream of `eop_detect`, the edge detector and the bit timer/shift register. Consumes their per-bit strobes and the assembled byte, then:
- validates the SYNC byte,
- issues one FIFO write strobe per received data byte,
- recognises a clean end-of-packet,
- flags framing errors (bad SYNC, EOP mid-byte).

---
 rtl/rcu_pkg.sv | 19 +
 rtl/rcu_if.sv | 23 ++
 rtl/rcu_flex_counter.sv | 37 +++
 rtl/rcu.sv | 115 +++++++++++
 tb/tb_rcu.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rcu_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CHK_SYNC,
        DATA,
        STORE,
        EOP_END,
        ERR_WAIT,
        ERR_EOP
    } rcu_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h80;
    localparam int unsigned BYTE_BITS         = 8;
    localparam int unsigned BIT_CNT_W         = $clog2(BYTE_BITS);

endpackage

// File: rtl/rcu_if.sv
// Per-bit strobes and assembled byte into the receiver control unit, status out.
interface rcu_if;

    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  rcving, w_enable, r_error
    );

    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output rcving, w_enable, r_error
    );

endinterface

// File: rtl/rcu_flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover value.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Next count: clear has priority over counting; wrap to zero after rollover value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rcu.sv
// Receiver control unit: SYNC check, per-byte FIFO write strobe, EOP/framing errors.
module rcu
    import usb_rcv_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input logic  clk,
    input logic  rst,
    rcu_if.slave bus
);

    rcu_state_t           state_q, state_d;
    logic                 r_error_q, r_error_d;
    logic                 eop_lat_q, eop_lat_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 eop_sample;
    logic                 cnt_clear;

    assign eop_sample = bus.shift_enable & bus.eop;
    assign cnt_clear  = bus.byte_received | ((state_q == IDLE) & bus.d_edge);

    flex_counter #(
        .NUM_CNT_BITS (BIT_CNT_W)
    ) u_bit_cnt (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (cnt_clear),
        .count_enable_i (bus.shift_enable & ~bus.eop),
        .rollover_val_i (BIT_CNT_W'(BYTE_BITS - 1)),
        .count_o        (bit_cnt)
    );

    // Next-state and error-flag logic; an EOP coinciding with a byte is latched for STORE.
    always_comb begin
        state_d   = state_q;
        r_error_d = r_error_q;
        eop_lat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_edge) begin
                    state_d   = SYNC;
                    r_error_d = 1'b0;
                end
            end
            SYNC: begin
                if (bus.byte_received) begin
                    state_d = CHK_SYNC;
                end else if (eop_sample) begin
                    state_d   = ERR_EOP;
                    r_error_d = 1'b1;
                end
            end
            CHK_SYNC: begin
                if (bus.rcv_data == SYNC_BYTE) begin
                    state_d = DATA;
                end else begin
                    state_d   = ERR_WAIT;
                    r_error_d = 1'b1;
                end
            end
            DATA: begin
                if (bus.byte_received) begin
                    state_d   = STORE;
                    eop_lat_d = eop_sample;
                end else if (eop_sample) begin
                    if (bit_cnt == '0) begin
                        state_d = EOP_END;
                    end else begin
                        state_d   = ERR_EOP;
                        r_error_d = 1'b1;
                    end
                end
            end
            STORE: begin
                state_d = eop_lat_q ? EOP_END : DATA;
            end
            EOP_END: begin
                if (bus.d_edge) begin
                    state_d = IDLE;
                end
            end
            ERR_WAIT: begin
                if (eop_sample) begin
                    state_d = ERR_EOP;
                end
            end
            ERR_EOP: begin
                if (bus.d_edge) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, sticky error and latched-EOP registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_error_q <= 1'b0;
            eop_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_error_q <= r_error_d;
            eop_lat_q <= eop_lat_d;
        end
    end

    assign bus.rcving   = (state_q != IDLE);
    assign bus.w_enable = (state_q == STORE);
    assign bus.r_error  = r_error_q;

endmodule

// File: tb/tb_rcu.sv
// Directed plus randomized packet-level bench for rcu with a protocol-level reference model.
module tb_rcu;

    localparam logic [7:0] SYNC_VAL = 8'h80;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rcu_if bus ();

    rcu #(.SYNC_BYTE(SYNC_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Protocol-level model state
    bit open, ended, bad, exp_we, exp_err, err_delay;
    int nb, shifts;
    int writes_obs;
    logic [7:0] pl[$];

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic de, input logic ev, input logic se,
                              input logic br, input logic [7:0] d);
        logic eop_s;
        eop_s  = se && ev;
        exp_we = 1'b0;
        if (rst) begin
            open = 0; ended = 0; bad = 0; nb = 0; shifts = 0;
            exp_err = 0; err_delay = 0;
            return;
        end
        if (err_delay) begin
            exp_err   = 1;
            err_delay = 0;
        end
        if (!open) begin
            if (de) begin
                open = 1; ended = 0; bad = 0; nb = 0; shifts = 0; exp_err = 0;
            end
        end else if (ended) begin
            if (de) open = 0;
        end else if (br) begin
            if (nb == 0) begin
                if (d != SYNC_VAL) begin
                    bad       = 1;
                    err_delay = 1;
                end
            end else if (!bad) begin
                exp_we = 1;
            end
            nb++;
            shifts = 0;
            if (eop_s) ended = 1;
        end else if (eop_s) begin
            ended = 1;
            if (!bad && (nb == 0 || (shifts % 8) != 0)) begin
                bad     = 1;
                exp_err = 1;
            end
        end else if (se) begin
            shifts++;
        end
    endtask

    task automatic tick(input logic de, input logic ev, input logic se,
                        input logic br, input logic [7:0] d);
        bus.d_edge        = de;
        bus.eop           = ev;
        bus.shift_enable  = se;
        bus.byte_received = br;
        if (br) bus.rcv_data = d;
        @(posedge clk);
        #1;
        model_step(de, ev, se, br, d);
        if (bus.w_enable === 1'b1) writes_obs++;
        chk("rcving", bus.rcving, open);
        chk("w_enable", bus.w_enable, exp_we);
        chk("r_error", bus.r_error, exp_err);
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_bit();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'($urandom % 2), 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat (8) send_bit();
        tick(1'b0, 1'b0, 1'b0, 1'b1, b);
        idle(1);
    endtask

    // Last byte completes on the same cycle as the first EOP sample.
    task automatic send_byte_eop(input logic [7:0] b);
        repeat (8) send_bit();
        tick(1'b0, 1'b1, 1'b1, 1'b1, b);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic send_eop();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    // mode 0: clean end, 1: EOP k bits into a byte, 2: last byte coincides with EOP,
    // 3: EOP after k bits before any byte. Data bytes come from pl.
    task automatic run_packet(input logic [7:0] sb, input int mode, input int k);
        int  n;
        int  exp_writes;
        bit  exp_err_end;
        bit  sync_ok;
        n          = pl.size();
        sync_ok    = (sb == SYNC_VAL);
        writes_obs = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1);
        if (mode == 3) begin
            repeat (k) send_bit();
            send_eop();
        end else begin
            send_byte(sb);
            for (int i = 0; i < n; i++) begin
                if (mode == 2 && i == n - 1) send_byte_eop(pl[i]);
                else send_byte(pl[i]);
            end
            if (mode == 1) repeat (k) send_bit();
            if (mode != 2) send_eop();
        end
        exp_writes  = (mode == 3 || !sync_ok) ? 0 : n;
        exp_err_end = (mode == 3 || mode == 1 || !sync_ok);
        chk_int("pkt_writes", writes_obs, exp_writes);
        chk("pkt_err", bus.r_error, exp_err_end);
        chk("pkt_idle", bus.rcving, 1'b0);
    endtask

    initial begin
        logic [7:0] sb;
        int         mode;
        int         n;
        rst               = 1'b1;
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_data      = 8'h00;

        do_reset();
        chk("reset_rcving", bus.rcving, 1'b0);
        chk("reset_wen", bus.w_enable, 1'b0);
        chk("reset_err", bus.r_error, 1'b0);
        idle(3);

        // Normal packet with two data bytes
        pl = '{8'hA5, 8'h3C};
        run_packet(SYNC_VAL, 0, 0);

        // Bad SYNC, error persists into IDLE, cleared by next packet start
        pl.delete();
        run_packet(8'h81, 0, 0);
        idle(2);
        chk("badsync_err_idle", bus.r_error, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("err_cleared_on_start", bus.r_error, 1'b0);
        send_eop();

        // EOP three bits into a data byte
        pl.delete();
        run_packet(SYNC_VAL, 1, 3);

        // Final byte coincides with EOP sample
        pl = '{8'h5A};
        run_packet(SYNC_VAL, 2, 0);

        // Reset during DATA after four shifts
        writes_obs = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1);
        send_byte(SYNC_VAL);
        repeat (4) send_bit();
        do_reset();
        chk("midrst_rcving", bus.rcving, 1'b0);
        chk("midrst_wen", bus.w_enable, 1'b0);
        chk("midrst_err", bus.r_error, 1'b0);
        idle(3);
        chk_int("midrst_writes", writes_obs, 0);
        pl = '{8'h11, 8'h22};
        run_packet(SYNC_VAL, 0, 0);

        // Randomized packets
        for (int p = 0; p < 25; p++) begin
            mode = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 4));
            if (mode == 2 && n == 0) n = 1;
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                sb = 8'($urandom);
                if (sb == SYNC_VAL) sb = sb ^ 8'h01;
            end else begin
                sb = SYNC_VAL;
            end
            run_packet(sb, mode, (mode == 3) ? int'($urandom_range(0, 7))
                                             : int'($urandom_range(1, 7)));
            idle(int'($urandom_range(1, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
